auth_initiator: RTL and testbench

//  Authentication initiator: the stage directly upstream of the authentication responder.

---
 rtl/auth_initiator_pkg.sv | 32 +++
 rtl/auth_timeout_timer.sv | 29 ++
 rtl/auth_initiator.sv | 151 +++++++++++++++
 tb/tb_auth_initiator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_initiator_pkg.sv
// rtl/auth_initiator_pkg.sv - shared widths, message codes, error codes and one-hot states
package auth_initiator_pkg;

  localparam int AUTH_MSG_LEN = 256;
  localparam int AUTH_HDR_W   = 8;

  localparam logic [7:0] T_GET_DIGESTS     = 8'h81;
  localparam logic [7:0] T_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] T_CHALLENGE       = 8'h83;
  localparam logic [7:0] T_DIGESTS         = 8'h01;
  localparam logic [7:0] T_CERTIFICATE     = 8'h02;
  localparam logic [7:0] T_CHALLENGE_AUTH  = 8'h03;
  localparam logic [7:0] T_ERROR           = 8'h7F;
  localparam logic [7:0] RSP_TYPE_MASK     = 8'h7F;

  localparam logic [2:0] ERR_OK          = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd1;
  localparam logic [2:0] ERR_BAD_VERSION = 3'd2;
  localparam logic [2:0] ERR_BAD_TYPE    = 3'd3;
  localparam logic [2:0] ERR_RESP_ERROR  = 3'd4;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_BUILD = 7'b0000010,
    S_WAIT  = 7'b0000100,
    S_RETRY = 7'b0001000,
    S_CHECK = 7'b0010000,
    S_ACK   = 7'b0100000,
    S_DONE  = 7'b1000000
  } state_e;

endpackage

// File: rtl/auth_timeout_timer.sv
// rtl/auth_timeout_timer.sv - saturating response-timeout counter
module auth_timeout_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Holds at LAST instead of wrapping so expiry stays asserted until cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && (cnt != LAST))
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/auth_initiator.sv
// rtl/auth_initiator.sv - authentication request initiator; AUTH_INIT_RETRY_EN enables timeout re-sends
module auth_initiator
  import auth_initiator_pkg::*;
#(
  parameter int MSG_LEN     = AUTH_MSG_LEN,
  parameter int HDR_VAR_W   = AUTH_HDR_W,
  parameter int PROTO_VER   = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRIES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [HDR_VAR_W-1:0]         msg_type_in,
  input  logic [HDR_VAR_W-1:0]         param1_in,
  input  logic [HDR_VAR_W-1:0]         param2_in,
  input  logic [MSG_LEN-4*HDR_VAR_W-1:0] payload_in,
  output logic                         auth_req_out,
  output logic [MSG_LEN-1:0]           auth_msg_req_out,
  input  logic                         resp_req_in,
  input  logic [MSG_LEN-1:0]           auth_msg_resp_in,
  output logic                         ack_out,
  output logic                         busy,
  output logic                         done,
  output logic [MSG_LEN-1:0]           rsp_msg,
  output logic [2:0]                   err_code
);

  localparam logic [HDR_VAR_W-1:0] VER      = HDR_VAR_W'(PROTO_VER);
  localparam logic [HDR_VAR_W-1:0] TYPE_ERR = HDR_VAR_W'(T_ERROR);
  localparam logic [HDR_VAR_W-1:0] TYPE_MSK = HDR_VAR_W'(RSP_TYPE_MASK);

  state_e               state, state_n;
  logic [MSG_LEN-1:0]   lat_msg;
  logic                 expired;
  logic [2:0]           check_err;
  logic [HDR_VAR_W-1:0] rsp_ver, rsp_type, req_type;

  assign rsp_ver  = rsp_msg[MSG_LEN-1 -: HDR_VAR_W];
  assign rsp_type = rsp_msg[MSG_LEN-HDR_VAR_W-1 -: HDR_VAR_W];
  assign req_type = lat_msg[MSG_LEN-HDR_VAR_W-1 -: HDR_VAR_W];

  auth_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != S_WAIT),
    .enable  (state == S_WAIT),
    .expired (expired)
  );

`ifdef AUTH_INIT_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retry_cnt;
  logic          retries_left;

  assign retries_left = (retry_cnt != RW'(MAX_RETRIES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retry_cnt <= '0;
    else if (state == S_IDLE)
      retry_cnt <= '0;
    else if ((state == S_RETRY) && retries_left)
      retry_cnt <= retry_cnt + 1'b1;
  end
`else
  logic unused_max_retries;
  assign unused_max_retries = ^MAX_RETRIES;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_BUILD;
      S_BUILD: state_n = S_WAIT;
      S_WAIT: begin
        // A response arriving on the expiry cycle still counts as answered
        if (resp_req_in)
          state_n = S_CHECK;
        else if (expired)
`ifdef AUTH_INIT_RETRY_EN
          state_n = S_RETRY;
`else
          state_n = S_DONE;
`endif
      end
`ifdef AUTH_INIT_RETRY_EN
      S_RETRY: state_n = retries_left ? S_WAIT : S_DONE;
`endif
      S_CHECK: state_n = S_ACK;
      S_ACK:   if (!resp_req_in) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    check_err = ERR_OK;
    if (rsp_ver != VER)
      check_err = ERR_BAD_VERSION;
    else if (rsp_type == TYPE_ERR)
      check_err = ERR_RESP_ERROR;
    else if (rsp_type != (req_type & TYPE_MSK))
      check_err = ERR_BAD_TYPE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_msg          <= '0;
      auth_msg_req_out <= '0;
      rsp_msg          <= '0;
      err_code         <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lat_msg  <= {VER, msg_type_in, param1_in, param2_in, payload_in};
          rsp_msg  <= '0;
          err_code <= ERR_OK;
        end
        S_BUILD: auth_msg_req_out <= lat_msg;
        S_WAIT: begin
          if (resp_req_in)
            rsp_msg <= auth_msg_resp_in;
`ifndef AUTH_INIT_RETRY_EN
          else if (expired)
            err_code <= ERR_TIMEOUT;
`endif
        end
`ifdef AUTH_INIT_RETRY_EN
        S_RETRY: if (!retries_left) err_code <= ERR_TIMEOUT;
`endif
        S_CHECK: err_code <= check_err;
        default: ;
      endcase
    end
  end

  // Handshake outputs decode straight from one-hot state flops
  assign auth_req_out = (state == S_WAIT);
  assign ack_out      = (state == S_ACK);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

endmodule

// File: tb/tb_auth_initiator.sv
// tb/tb_auth_initiator.sv - randomized self-checking bench for auth_initiator
module tb_auth_initiator;

  localparam int ML   = 256;
  localparam int TO   = 16;
  localparam int MAXR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    msg_type_in = '0, param1_in = '0, param2_in = '0;
  logic [ML-33:0] payload_in = '0;
  logic          resp_req_in = 1'b0;
  logic [ML-1:0] auth_msg_resp_in = '0;
  logic          auth_req_out, ack_out, busy, done;
  logic [ML-1:0] auth_msg_req_out, rsp_msg;
  logic [2:0]    err_code;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  auth_initiator #(
    .MSG_LEN(ML), .HDR_VAR_W(8), .PROTO_VER(1), .TIMEOUT_CYC(TO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .msg_type_in(msg_type_in), .param1_in(param1_in), .param2_in(param2_in),
    .payload_in(payload_in), .auth_req_out(auth_req_out), .auth_msg_req_out(auth_msg_req_out),
    .resp_req_in(resp_req_in), .auth_msg_resp_in(auth_msg_resp_in), .ack_out(ack_out),
    .busy(busy), .done(done), .rsp_msg(rsp_msg), .err_code(err_code)
  );

  function automatic logic [ML-1:0] rand256();
    logic [ML-1:0] v;
    for (int i = 0; i < ML / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ML-1:0] mk_rsp(input logic [7:0] ver, input logic [7:0] ty,
                                            input logic [7:0] p1);
    logic [ML-1:0] body;
    body = rand256();
    return {ver, ty, p1, body[ML-25:0]};
  endfunction

  // Expected error code from the header rules, first matching rule wins
  function automatic logic [2:0] model_err(input logic [7:0] req_ty, input logic [ML-1:0] r);
    int ver, ty;
    ver = int'(r[ML-1 -: 8]);
    ty  = int'(r[ML-9 -: 8]);
    if (ver != 1) return 3'd2;
    if (ty == 127) return 3'd4;
    if (ty != int'(req_ty) % 128) return 3'd3;
    return 3'd0;
  endfunction

  task automatic run_txn(input logic [7:0] ty, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [ML-33:0] pl, input logic [ML-1:0] rsp,
                         input int dly, input int hold, input bit poke, input string nm);
    logic [ML-1:0] exp_req;
    logic [2:0]    exp_err;
    exp_req = {8'd1, ty, p1, p2, pl};
    exp_err = model_err(ty, rsp);
    @(negedge clk);
    start = 1'b1; msg_type_in = ty; param1_in = p1; param2_in = p2; payload_in = pl;
    @(negedge clk);
    start = 1'b0; msg_type_in = 8'($urandom); payload_in = 224'(rand256());
    checks++;
    if (busy !== 1'b1 || auth_req_out !== 1'b0)
      $display("FAIL %s build: busy=%0b req=%0b want busy=1 req=0", nm, busy, auth_req_out);
    else passed++;
    @(negedge clk);
    checks++;
    if (auth_req_out !== 1'b1 || auth_msg_req_out !== exp_req)
      $display("FAIL %s request: req=%0b msg=%h want req=1 msg=%h", nm, auth_req_out, auth_msg_req_out, exp_req);
    else passed++;
    if (poke) begin
      start = 1'b1; msg_type_in = 8'h83; param1_in = 8'($urandom); payload_in = 224'(rand256());
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (auth_req_out !== 1'b1 || ack_out !== 1'b0)
        $display("FAIL %s wait: req=%0b ack=%0b want req=1 ack=0", nm, auth_req_out, ack_out);
      else passed++;
    end
    resp_req_in = 1'b1; auth_msg_resp_in = rsp;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (auth_req_out !== 1'b0 || ack_out !== 1'b0 || done !== 1'b0)
      $display("FAIL %s check: req=%0b ack=%0b done=%0b want 0 0 0", nm, auth_req_out, ack_out, done);
    else passed++;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      checks++;
      if (ack_out !== 1'b1 || done !== 1'b0)
        $display("FAIL %s ack: ack=%0b done=%0b want ack=1 done=0", nm, ack_out, done);
      else passed++;
    end
    resp_req_in = 1'b0; auth_msg_resp_in = rand256();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ack_out !== 1'b0 || busy !== 1'b1 || err_code !== exp_err || rsp_msg !== rsp)
      $display("FAIL %s done: done=%0b ack=%0b busy=%0b err=%0d rsp=%h want 1 0 1 err=%0d rsp=%h",
               nm, done, ack_out, busy, err_code, rsp_msg, exp_err, rsp);
    else passed++;
    if (poke) begin
      start = 1'b1; msg_type_in = 8'h82; param2_in = 8'($urandom); payload_in = 224'(rand256());
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle: done=%0b busy=%0b want 0 0", nm, done, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || auth_req_out !== 1'b0 || auth_msg_req_out !== exp_req)
      $display("FAIL %s held: busy=%0b req=%0b msg=%h want 0 0 msg=%h", nm, busy, auth_req_out, auth_msg_req_out, exp_req);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({auth_req_out, ack_out, busy, done} !== 4'b0 || err_code !== 3'd0 || rsp_msg !== '0 || auth_msg_req_out !== '0)
      $display("FAIL reset: req=%0b ack=%0b busy=%0b done=%0b err=%0d want all 0",
               auth_req_out, ack_out, busy, done, err_code);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_txn(8'h81, 8'h11, 8'h22, 224'(rand256()), mk_rsp(8'd1, 8'h01, 8'h00), 5, 2, 1'b0, "basic");
  endtask

  task automatic test_bad_version();
    run_txn(8'h81, 8'h00, 8'h01, 224'(rand256()), mk_rsp(8'd2, 8'h01, 8'h00), 3, 1, 1'b0, "badver");
  endtask

  task automatic test_error_resp();
    logic [7:0] p1f;
    run_txn(8'h82, 8'h05, 8'h06, 224'(rand256()), mk_rsp(8'd1, 8'h7F, 8'h03), 2, 0, 1'b0, "errrsp");
    p1f = rsp_msg[ML-17 -: 8];
    checks++;
    if (p1f !== 8'h03 || err_code !== 3'd4)
      $display("FAIL errrsp_param1: p1=%h err=%0d want p1=03 err=4", p1f, err_code);
    else passed++;
  endtask

  task automatic test_timeout();
    int done_at, drops, highs, low_run, acks, exp_done, exp_drops, exp_highs;
    done_at = -1; drops = 0; highs = 0; low_run = 0; acks = 0;
`ifdef AUTH_INIT_RETRY_EN
    exp_drops = MAXR; exp_highs = (MAXR + 1) * TO; exp_done = 2 + (MAXR + 1) * (TO + 1);
`else
    exp_drops = 0; exp_highs = TO; exp_done = 2 + TO;
`endif
    @(negedge clk);
    start = 1'b1; msg_type_in = 8'h83; payload_in = 224'(rand256());
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < 400 && done_at < 0; i++) begin
      @(negedge clk);
      if (ack_out) acks++;
      if (auth_req_out) begin
        if (low_run == 1) drops++;
        highs++;
        low_run = 0;
      end else if (highs > 0) low_run++;
      if (done) done_at = i;
    end
    checks++;
    if (done_at != exp_done)
      $display("FAIL timeout_done_cycle: got %0d want %0d", done_at, exp_done);
    else passed++;
    checks++;
    if (drops != exp_drops || highs != exp_highs)
      $display("FAIL timeout_req_pattern: drops=%0d highs=%0d want drops=%0d highs=%0d", drops, highs, exp_drops, exp_highs);
    else passed++;
    checks++;
    if (err_code !== 3'd1 || acks != 0 || rsp_msg !== '0)
      $display("FAIL timeout_result: err=%0d acks=%0d want err=1 acks=0", err_code, acks);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_ack();
    bit seen;
    @(negedge clk);
    start = 1'b1; msg_type_in = 8'h81; payload_in = 224'(rand256());
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resp_req_in = 1'b1; auth_msg_resp_in = mk_rsp(8'd1, 8'h01, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (ack_out !== 1'b1)
      $display("FAIL rst_ack_pre: ack=%0b want 1", ack_out);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ack_out !== 1'b0 || auth_req_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rsp_msg !== '0)
      $display("FAIL rst_async: ack=%0b req=%0b busy=%0b done=%0b want all 0", ack_out, auth_req_out, busy, done);
    else passed++;
    resp_req_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen)
      $display("FAIL rst_no_done: done seen=1 want 0");
    else passed++;
    run_txn(8'h83, 8'h44, 8'h55, 224'(rand256()), mk_rsp(8'd1, 8'h03, 8'h00), 1, 1, 1'b0, "after_rst");
  endtask

  task automatic test_ignored_start();
    run_txn(8'h82, 8'h99, 8'hAA, 224'(rand256()), mk_rsp(8'd1, 8'h02, 8'h00), 4, 1, 1'b1, "ignored");
  endtask

  task automatic test_random();
    logic [7:0]    ty, rv, rt;
    logic [ML-1:0] rsp;
    for (int n = 0; n < 20; n++) begin
      ty = 8'h81 + 8'($urandom_range(0, 2));
      rv = 8'd1;
      rt = ty - 8'h80;
      case ($urandom_range(0, 3))
        1: begin rv = 8'($urandom_range(0, 255)); if (rv == 8'd1) rv = 8'd0; end
        2: rt = 8'h7F;
        3: begin rt = 8'($urandom_range(0, 255)); if (rt == ty - 8'h80 || rt == 8'h7F) rt = 8'h55; end
        default: ;
      endcase
      rsp = mk_rsp(rv, rt, 8'($urandom));
      run_txn(ty, 8'($urandom), 8'($urandom), 224'(rand256()), rsp,
              $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_version();
    test_error_resp();
    test_timeout();
    test_reset_mid_ack();
    test_ignored_start();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
